// File: rtl/r2rs_pkg.sv
// Shared types and helpers for the r2rs router-side blocks.
package r2rs_pkg;

    localparam int unsigned FLIT_W_DEF = 30;
    localparam int unsigned GNT_W      = 3;
    localparam int unsigned PORT_W     = 2;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        DROP = 2'd3
    } inj_state_t;

    // A grant is usable only when exactly one port bit is set.
    function automatic logic gnt_is_onehot(input logic [GNT_W-1:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

    function automatic port_idx_t gnt_to_port(input logic [GNT_W-1:0] code);
        case (code)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/r2rs_flit_fifo.sv
// Power-of-two flit FIFO; head entry is read straight from the storage registers.
module r2rs_flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/r2rs_port_injector.sv
// Source-side packet injector: route request, one-hot grant decode, credit-gated send or drop.
// Optional grant-wait timeout is built when R2RS_INJ_TIMEOUT_EN is defined.
module r2rs_port_injector
    import r2rs_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FLIT_W  = FLIT_W_DEF,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_last,
    output logic              req_valid,
    output logic [FLIT_W-1:0] req_hdr,
    input  logic              gnt_valid,
    input  logic [GNT_W-1:0]  gnt_code,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_last,
    output logic [PORT_W-1:0] out_port,
    input  logic              credit_ret,
    output logic              drop_pulse,
    output logic              busy
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CREDITS == 0 || TIMEOUT == 0) begin : g_bad_param
        $error("r2rs_port_injector: invalid parameter set");
    end

    inj_state_t      state;
    inj_state_t      state_nxt;
    logic [FLIT_W:0] head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic [CW-1:0]   credit_cnt;
    port_idx_t       port_q;
    logic            tmo_hit;

    r2rs_flit_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   ({in_last, in_data}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE);
    assign out_port = port_q;

`ifdef R2RS_INJ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts cycles spent in REQ; zero on the entry cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else        tmo_cnt <= (state == REQ) ? tmo_cnt + TW'(1) : '0;
    end

    assign tmo_hit = (state == REQ) && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A grant in the last wait cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = REQ;
            REQ: begin
                if (gnt_valid)    state_nxt = gnt_is_onehot(gnt_code) ? SEND : DROP;
                else if (tmo_hit) state_nxt = DROP;
            end
            SEND:    if (out_valid && head[FLIT_W]) state_nxt = IDLE;
            DROP:    if (drop_pulse) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_valid  = 1'b0;
        req_hdr    = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        drop_pulse = 1'b0;
        pop        = 1'b0;
        case (state)
            REQ: begin
                req_valid = 1'b1;
                req_hdr   = head[FLIT_W-1:0];
            end
            SEND: begin
                if (!fifo_empty && credit_cnt != '0) begin
                    out_valid = 1'b1;
                    out_data  = head[FLIT_W-1:0];
                    out_last  = head[FLIT_W];
                    pop       = 1'b1;
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    drop_pulse = head[FLIT_W];
                end
            end
            default: ;
        endcase
    end

    // Send and return in the same cycle cancel; returns beyond CREDITS are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CW'(CREDITS);
        end else if (out_valid && !credit_ret) begin
            credit_cnt <= credit_cnt - CW'(1);
        end else if (!out_valid && credit_ret && credit_cnt != CW'(CREDITS)) begin
            credit_cnt <= credit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q <= '0;
        end else if (state == REQ && gnt_valid && gnt_is_onehot(gnt_code)) begin
            port_q <= gnt_to_port(gnt_code);
        end
    end

endmodule

// File: tb/tb_r2rs_port_injector.sv
// Directed bench for r2rs_port_injector; timeout checks build when R2RS_INJ_TIMEOUT_EN is defined.
module tb_r2rs_port_injector;
    import r2rs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_data;
    logic        in_last;
    logic        req_valid;
    logic [29:0] req_hdr;
    logic        gnt_valid;
    logic [2:0]  gnt_code;
    logic        out_valid;
    logic [29:0] out_data;
    logic        out_last;
    logic [1:0]  out_port;
    logic        credit_ret;
    logic        drop_pulse;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int nv;
    int nd;
    int n;

    logic [30:0] src_q[$];

    r2rs_port_injector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .req_valid  (req_valid),
        .req_hdr    (req_hdr),
        .gnt_valid  (gnt_valid),
        .gnt_code   (gnt_code),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_port   (out_port),
        .credit_ret (credit_ret),
        .drop_pulse (drop_pulse),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic enqueue(input int cnt, input logic [29:0] base);
        for (int i = 0; i < cnt; i++) begin
            src_q.push_back({(i == cnt - 1), base + 30'(i)});
        end
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!req_valid && cycles < 40);
        if (!req_valid) check("req_wait", 32'(req_valid), 32'd1);
    endtask

    task automatic grant(input logic [2:0] code);
        gnt_valid = 1'b1;
        gnt_code  = code;
        step();
        gnt_valid = 1'b0;
        gnt_code  = 3'b000;
    endtask

    task automatic run_count(input int cycles, output int v, output int d);
        v = 0;
        d = 0;
        for (int i = 0; i < cycles; i++) begin
            v += int'(out_valid);
            d += int'(drop_pulse);
            step();
        end
    endtask

    // Source model: offers the queue head, retires it once a handshake has been seen.
    initial begin : feeder
        logic hs;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready && rst_n;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                in_valid           = 1'b1;
                {in_last, in_data} = src_q[0];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        gnt_valid  = 1'b0;
        gnt_code   = 3'b000;
        credit_ret = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_hdr", 32'(req_hdr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_credit", 32'(dut.credit_cnt), 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 3-flit packet granted to port 1
        src_q.push_back({1'b0, 30'h0000_1234});
        src_q.push_back({1'b0, 30'h0000_0AAA});
        src_q.push_back({1'b1, 30'h0000_0BBB});
        wait_req(n);
        check("req_latency", 32'(n), 32'd3);
        check("req_hdr", 32'(req_hdr), 32'h1234);
        grant(3'b010);
        check("p1_port", 32'(out_port), 32'd1);
        check("p1_f0_valid", 32'(out_valid), 32'd1);
        check("p1_f0_data", 32'(out_data), 32'h1234);
        check("p1_f0_last", 32'(out_last), 32'd0);
        step();
        check("p1_f1_data", 32'(out_data), 32'h0AAA);
        check("p1_f1_last", 32'(out_last), 32'd0);
        step();
        check("p1_f2_data", 32'(out_data), 32'h0BBB);
        check("p1_f2_last", 32'(out_last), 32'd1);
        step();
        check("p1_done_valid", 32'(out_valid), 32'd0);
        check("p1_done_busy", 32'(busy), 32'd0);
        check("p1_credit", 32'(dut.credit_cnt), 32'd1);

        // Grant outside REQ must be ignored
        grant(3'b100);
        check("idle_gnt_busy", 32'(busy), 32'd0);
        check("idle_gnt_port", 32'(out_port), 32'd1);

        // Four returns from 1: last one saturates at 4
        credit_ret = 1'b1;
        repeat (4) step();
        credit_ret = 1'b0;
        check("credit_sat", 32'(dut.credit_cnt), 32'd4);

        // Zero-bit grant rejects the packet
        enqueue(2, 30'h2000);
        wait_req(n);
        check("rej0_hdr", 32'(req_hdr), 32'h2000);
        grant(3'b000);
        run_count(8, nv, nd);
        check("rej0_out", 32'(nv), 32'd0);
        check("rej0_drop", 32'(nd), 32'd1);
        check("rej0_busy", 32'(busy), 32'd0);

        // Multi-bit grant rejects the packet
        enqueue(2, 30'h3000);
        wait_req(n);
        grant(3'b011);
        run_count(8, nv, nd);
        check("rej3_out", 32'(nv), 32'd0);
        check("rej3_drop", 32'(nd), 32'd1);
        check("rej3_busy", 32'(busy), 32'd0);
        check("port_hold", 32'(out_port), 32'd1);

        // 6-flit packet with 4 credits
        enqueue(6, 30'h600);
        wait_req(n);
        grant(3'b001);
        check("cr_port", 32'(out_port), 32'd0);
        run_count(10, nv, nd);
        check("cr_burst", 32'(nv), 32'd4);
        check("cr_stall_valid", 32'(out_valid), 32'd0);
        check("cr_stall_cnt", 32'(dut.credit_cnt), 32'd0);
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        check("cr_one_valid", 32'(out_valid), 32'd1);
        check("cr_one_data", 32'(out_data), 32'h604);
        step();
        run_count(4, nv, nd);
        check("cr_one_only", 32'(nv), 32'd0);
        credit_ret = 1'b1;
        step();
        check("cr_both_data", 32'(out_data), 32'h605);
        check("cr_both_last", 32'(out_last), 32'd1);
        step();
        credit_ret = 1'b0;
        check("cr_both_cnt", 32'(dut.credit_cnt), 32'd1);
        check("cr_both_busy", 32'(busy), 32'd0);
        credit_ret = 1'b1;
        repeat (3) step();
        credit_ret = 1'b0;
        check("cr_restore", 32'(dut.credit_cnt), 32'd4);

        // FIFO fill with no grant, then reset in the middle of SEND
        enqueue(5, 30'h5000);
        wait_req(n);
        repeat (4) step();
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_left", 32'(src_q.size()), 32'd1);
        check("fill_req", 32'(req_valid), 32'd1);
        grant(3'b100);
        check("fill_port", 32'(out_port), 32'd2);
        check("fill_f0", 32'(out_data), 32'h5000);
        step();
        check("fill_f1", 32'(out_data), 32'h5001);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_port", 32'(out_port), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_credit", 32'(dut.credit_cnt), 32'd4);
        src_q.delete();
        step();
        step();
        rst_n = 1'b1;
        run_count(6, nv, nd);
        check("post_rst_out", 32'(nv), 32'd0);
        check("post_rst_drop", 32'(nd), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

`ifdef R2RS_INJ_TIMEOUT_EN
        enqueue(1, 30'h7000);
        wait_req(n);
        n = 0;
        do begin
            step();
            n++;
        end while (!drop_pulse && n < 40);
        check("tmo_drop_cycle", 32'(n), 32'd15);
        step();
        check("tmo_busy", 32'(busy), 32'd0);
        enqueue(1, 30'h7100);
        wait_req(n);
        repeat (14) step();
        grant(3'b010);
        check("tmo_gnt_wins", 32'(out_valid), 32'd1);
        check("tmo_gnt_data", 32'(out_data), 32'h7100);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
